// File: rtl/decode_pkg.sv
// decode_pkg: opcodes, operation bit indices and the decoded-entry type shared by the decode stage
package decode_pkg;
  localparam int INSTR_W = 48;
  localparam int XLEN = 32;
  localparam logic [6:0] OP_R = 7'h33, OP_IMM = 7'h13, OP_LOAD = 7'h03, OP_STORE = 7'h23;
  localparam logic [6:0] OP_BRANCH = 7'h63, OP_JAL = 7'h6F, OP_JALR = 7'h67, OP_LUI = 7'h37;
  localparam logic [6:0] OP_AUIPC = 7'h17, OP_SYSTEM = 7'h73, OP_FENCE = 7'h0F;
  localparam logic [5:0] I_ADD = 6'd0, I_SUB = 6'd1, I_XOR = 6'd2, I_OR = 6'd3, I_AND = 6'd4;
  localparam logic [5:0] I_SLL = 6'd5, I_SRL = 6'd6, I_SRA = 6'd7, I_SLT = 6'd8, I_SLTU = 6'd9;
  localparam logic [5:0] I_ADDI = 6'd10, I_XORI = 6'd11, I_ORI = 6'd12, I_ANDI = 6'd13, I_SLLI = 6'd14;
  localparam logic [5:0] I_SRLI = 6'd15, I_SRAI = 6'd16, I_SLTI = 6'd17, I_SLTIU = 6'd18;
  localparam logic [5:0] I_LB = 6'd19, I_LH = 6'd20, I_LW = 6'd21, I_LBU = 6'd22, I_LHU = 6'd23;
  localparam logic [5:0] I_SB = 6'd24, I_SH = 6'd25, I_SW = 6'd26;
  localparam logic [5:0] I_BEQ = 6'd27, I_BNE = 6'd28, I_BLT = 6'd29, I_BGE = 6'd30, I_BLTU = 6'd31, I_BGEU = 6'd32;
  localparam logic [5:0] I_JAL = 6'd33, I_JALR = 6'd34, I_LUI = 6'd35, I_AUIPC = 6'd36;
  localparam logic [5:0] I_ECALL = 6'd37, I_EBREAK = 6'd38, I_FENCE = 6'd39;
  localparam logic [5:0] I_MUL = 6'd40, I_MULH = 6'd41, I_MULHU = 6'd42, I_MULHSU = 6'd43;
  localparam logic [5:0] I_DIV = 6'd44, I_DIVU = 6'd45, I_REM = 6'd46, I_REMU = 6'd47;
  typedef struct packed {
    logic [INSTR_W-1:0] instructions;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic [XLEN-1:0] imm;
    logic [XLEN-1:0] pc;
    logic illegal;
  } entry_t;
endpackage

// File: rtl/decode_stage_rv32im_decode_comb.sv
// rv32im_decode_comb: purely combinational RV32IM instruction word to one-hot op, fields and immediate
module rv32im_decode_comb import decode_pkg::*; (
  input  logic [31:0] i_instr,
  output logic [INSTR_W-1:0] o_instructions,
  output logic [4:0] o_rs1,
  output logic [4:0] o_rs2,
  output logic [4:0] o_rd,
  output logic [XLEN-1:0] o_imm,
  output logic o_illegal
);
  logic [6:0] w_op, w_f7;
  logic [2:0] w_f3;
  logic [5:0] w_idx;
  logic w_ok;
  assign w_op = i_instr[6:0];
  assign w_f3 = i_instr[14:12];
  assign w_f7 = i_instr[31:25];
  assign o_rs1 = i_instr[19:15];
  assign o_rs2 = i_instr[24:20];
  assign o_rd = i_instr[11:7];
  assign o_illegal = !w_ok;
  assign o_instructions = w_ok ? {{(INSTR_W-1){1'b0}}, 1'b1} << w_idx : '0;
  assign o_imm = (w_op == OP_IMM || w_op == OP_LOAD || w_op == OP_JALR || w_op == OP_SYSTEM || w_op == OP_FENCE)
                   ? {{(XLEN-12){i_instr[31]}}, i_instr[31:20]}
               : w_op == OP_STORE ? {{(XLEN-12){i_instr[31]}}, i_instr[31:25], i_instr[11:7]}
               : w_op == OP_BRANCH ? {{(XLEN-13){i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0}
               : (w_op == OP_LUI || w_op == OP_AUIPC) ? {i_instr[31:12], 12'h000}
               : w_op == OP_JAL ? {{(XLEN-21){i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0}
               : '0;
  // select the operation index and flag encodings outside RV32IM
  always_comb begin
    w_ok = 1'b1;
    w_idx = I_ADD;
    case (w_op)
      OP_R: case (w_f7)
        7'h00: case (w_f3)
          3'd0: w_idx = I_ADD;
          3'd1: w_idx = I_SLL;
          3'd2: w_idx = I_SLT;
          3'd3: w_idx = I_SLTU;
          3'd4: w_idx = I_XOR;
          3'd5: w_idx = I_SRL;
          3'd6: w_idx = I_OR;
          default: w_idx = I_AND;
        endcase
        7'h20: begin
          w_idx = w_f3 == 3'd0 ? I_SUB : I_SRA;
          w_ok = w_f3 == 3'd0 || w_f3 == 3'd5;
        end
        7'h01: case (w_f3)
          3'd0: w_idx = I_MUL;
          3'd1: w_idx = I_MULH;
          3'd2: w_idx = I_MULHSU;
          3'd3: w_idx = I_MULHU;
          3'd4: w_idx = I_DIV;
          3'd5: w_idx = I_DIVU;
          3'd6: w_idx = I_REM;
          default: w_idx = I_REMU;
        endcase
        default: w_ok = 1'b0;
      endcase
      OP_IMM: case (w_f3)
        3'd0: w_idx = I_ADDI;
        3'd1: begin
          w_idx = I_SLLI;
          w_ok = w_f7 == 7'h00;
        end
        3'd2: w_idx = I_SLTI;
        3'd3: w_idx = I_SLTIU;
        3'd4: w_idx = I_XORI;
        3'd5: begin
          w_idx = w_f7[5] ? I_SRAI : I_SRLI;
          w_ok = w_f7 == 7'h00 || w_f7 == 7'h20;
        end
        3'd6: w_idx = I_ORI;
        default: w_idx = I_ANDI;
      endcase
      OP_LOAD: case (w_f3)
        3'd0: w_idx = I_LB;
        3'd1: w_idx = I_LH;
        3'd2: w_idx = I_LW;
        3'd4: w_idx = I_LBU;
        3'd5: w_idx = I_LHU;
        default: w_ok = 1'b0;
      endcase
      OP_STORE: case (w_f3)
        3'd0: w_idx = I_SB;
        3'd1: w_idx = I_SH;
        3'd2: w_idx = I_SW;
        default: w_ok = 1'b0;
      endcase
      OP_BRANCH: case (w_f3)
        3'd0: w_idx = I_BEQ;
        3'd1: w_idx = I_BNE;
        3'd4: w_idx = I_BLT;
        3'd5: w_idx = I_BGE;
        3'd6: w_idx = I_BLTU;
        3'd7: w_idx = I_BGEU;
        default: w_ok = 1'b0;
      endcase
      OP_JAL: w_idx = I_JAL;
      OP_JALR: begin
        w_idx = I_JALR;
        w_ok = w_f3 == 3'd0;
      end
      OP_LUI: w_idx = I_LUI;
      OP_AUIPC: w_idx = I_AUIPC;
      OP_SYSTEM: begin
        w_idx = i_instr[20] ? I_EBREAK : I_ECALL;
        w_ok = i_instr[31:21] == 11'd0 && i_instr[19:7] == 13'd0;
      end
      OP_FENCE: begin
        w_idx = I_FENCE;
        w_ok = w_f3 == 3'd0;
      end
      default: w_ok = 1'b0;
    endcase
  end
endmodule

// File: rtl/decode_stage.sv
// decode_stage: RV32IM decode with a 2-entry skid buffer between fetch and execute
module decode_stage #(
  parameter int INSTR_W = 48,
  parameter int XLEN = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic flush,
  input  logic in_valid,
  output logic in_ready,
  input  logic [31:0] in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic out_valid,
  input  logic out_ready,
  output logic [INSTR_W-1:0] instructions,
  output logic [4:0] rs1_addr,
  output logic [4:0] rs2_addr,
  output logic [4:0] rd_addr,
  output logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] pc_out,
  output logic illegal
);
  import decode_pkg::*;
  localparam logic [1:0] S_EMPTY = 2'd0, S_ONE = 2'd1, S_FULL = 2'd2;
  logic [1:0] r_state, w_next;
  logic r_in_ready, r_out_valid, w_acc, w_con, w_ill;
  logic [INSTR_W-1:0] w_ins;
  logic [4:0] w_rs1, w_rs2, w_rd;
  logic [XLEN-1:0] w_imm;
  entry_t r_head, r_skid, w_dec;
  rv32im_decode_comb u_dec (
    .i_instr(in_instr),
    .o_instructions(w_ins),
    .o_rs1(w_rs1),
    .o_rs2(w_rs2),
    .o_rd(w_rd),
    .o_imm(w_imm),
    .o_illegal(w_ill)
  );
  assign w_dec = {w_ins, w_rs1, w_rs2, w_rd, w_imm, in_pc, w_ill};
  assign w_acc = in_valid && r_in_ready;
  assign w_con = r_out_valid && out_ready;
  assign w_next = r_state == S_EMPTY ? (w_acc ? S_ONE : S_EMPTY)
                : r_state == S_ONE ? (w_acc == w_con ? S_ONE : w_acc ? S_FULL : S_EMPTY)
                : (w_con ? S_ONE : S_FULL);
  assign in_ready = r_in_ready;
  assign out_valid = r_out_valid;
  assign instructions = r_head.instructions;
  assign rs1_addr = r_head.rs1;
  assign rs2_addr = r_head.rs2;
  assign rd_addr = r_head.rd;
  assign imm = r_head.imm;
  assign pc_out = r_head.pc;
  assign illegal = r_head.illegal;
  // buffer state and registered handshake flags; flush empties the buffer ahead of any transfer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_EMPTY;
      r_in_ready <= 1'b1;
      r_out_valid <= 1'b0;
    end else begin
      r_state <= flush ? S_EMPTY : w_next;
      r_in_ready <= flush || w_next != S_FULL;
      r_out_valid <= !flush && w_next != S_EMPTY;
    end
  end
  // head takes the new word when it is free or being consumed, otherwise the skid slot does
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_head <= '0;
      r_skid <= '0;
    end else if (!flush) begin
      if (w_acc && (r_state == S_EMPTY || w_con)) r_head <= w_dec;
      else if (r_state == S_FULL && w_con) r_head <= r_skid;
      if (w_acc && r_state == S_ONE && !w_con) r_skid <= w_dec;
    end
  end
endmodule

// File: tb/tb_decode_stage.sv
// tb_decode_stage: directed scoreboard bench for the decode stage handshake and decoder
module tb_decode_stage;
  logic clk = 1'b0, rst = 1'b1, flush = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic in_ready, out_valid, illegal;
  logic [47:0] instructions;
  logic [4:0] rs1_addr, rs2_addr, rd_addr;
  logic [31:0] imm, pc_out;
  int checks = 0, failures = 0;
  logic [127:0] q[$];
  logic [127:0] cur;
  logic acc;
  logic [31:0] pcv = 32'h1000;
  logic [31:0] sw[4];
  int idx;

  always #5 clk = ~clk;

  decode_stage dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_instr(in_instr), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
    .instructions(instructions), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
    .imm(imm), .pc_out(pc_out), .illegal(illegal)
  );

  function automatic logic [127:0] ex(logic [31:0] w, int b, logic [31:0] im, logic [31:0] pc);
    logic [47:0] ins;
    ins = (b < 0) ? 48'd0 : (48'd1 << b);
    return {ins, w[19:15], w[24:20], w[11:7], im, pc, b < 0};
  endfunction

  function automatic logic [127:0] outs();
    return {instructions, rs1_addr, rs2_addr, rd_addr, imm, pc_out, illegal};
  endfunction

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    logic [127:0] e;
    acc = 1'b0;
    @(negedge clk);
    if (flush) q.delete();
    else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) chk("unexpected_out", 128'(out_valid), 128'd0);
        else begin
          e = q.pop_front();
          chk("entry", outs(), e);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(cur);
        acc = 1'b1;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic present(logic [31:0] w, int b, logic [31:0] im);
    in_valid = 1'b1;
    in_instr = w;
    in_pc = pcv;
    cur = ex(w, b, im, pcv);
  endtask

  task automatic send(logic [31:0] w, int b, logic [31:0] im);
    present(w, b, im);
    for (int i = 0; i < 20; i++) begin
      cyc();
      if (acc) break;
    end
    chk("accept", 128'(acc), 128'd1);
    in_valid = 1'b0;
    pcv += 4;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && q.size() != 0; i++) cyc();
    chk("drain", 128'(q.size()), 128'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    #11;
    chk("rst_valid", 128'(out_valid), 128'd0);
    chk("rst_ready", 128'(in_ready), 128'd1);
    chk("rst_fields", outs(), 128'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h002081B3, 0, 32'h0);
    chk("latency_valid", 128'(out_valid), 128'd1);
    send(32'hFFF00293, 10, 32'hFFFFFFFF);
    send(32'h023100B3, 40, 32'h0);
    send(32'h0220F1B3, 47, 32'h0);
    send(32'h123453B7, 35, 32'h12345000);
    send(32'hFE20AE23, 26, 32'hFFFFFFFC);
    send(32'hFE208CE3, 27, 32'hFFFFFFF8);
    send(32'h001000EF, 33, 32'h00000800);
    send(32'h4032D213, 16, 32'h00000403);
    send(32'h01012303, 21, 32'h00000010);
    send(32'h00000073, 37, 32'h0);
    send(32'h00100073, 38, 32'h1);
    send(32'h00000000, -1, 32'h0);
    send(32'hFE0081B3, -1, 32'h0);
    drain();
    for (int k = 0; k < 4; k++) sw[k] = {7'h00, 5'(k + 1), 5'(k + 2), 3'b000, 5'(10 + k), 7'h33};
    out_ready = 1'b0;
    idx = 0;
    for (int i = 0; i < 3; i++) begin
      present(sw[idx], 0, 32'h0);
      in_pc = 32'h100 + 32'(4 * idx);
      cur = ex(sw[idx], 0, 32'h0, in_pc);
      cyc();
      if (acc) idx++;
    end
    chk("stall_accepted", 128'(idx), 128'd2);
    chk("stall_ready", 128'(in_ready), 128'd0);
    chk("stall_head", outs(), ex(sw[0], 0, 32'h0, 32'h100));
    cyc();
    chk("stall_noacc", 128'(acc), 128'd0);
    chk("stall_hold", outs(), ex(sw[0], 0, 32'h0, 32'h100));
    out_ready = 1'b1;
    for (int i = 0; i < 20 && idx < 4; i++) begin
      present(sw[idx], 0, 32'h0);
      in_pc = 32'h100 + 32'(4 * idx);
      cur = ex(sw[idx], 0, 32'h0, in_pc);
      cyc();
      if (acc) idx++;
    end
    in_valid = 1'b0;
    chk("stall_all", 128'(idx), 128'd4);
    drain();
    out_ready = 1'b0;
    send(32'h002081B3, 0, 32'h0);
    send(32'hFFF00293, 10, 32'hFFFFFFFF);
    chk("full_ready", 128'(in_ready), 128'd0);
    flush = 1'b1;
    present(32'h00A58A33, 0, 32'h0);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_valid", 128'(out_valid), 128'd0);
    chk("flush_ready", 128'(in_ready), 128'd1);
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("flush_quiet", 128'(out_valid), 128'd0);
    out_ready = 1'b0;
    send(32'h023100B3, 40, 32'h0);
    flush = 1'b1;
    present(32'h00A58A33, 0, 32'h0);
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    chk("flush_one_valid", 128'(out_valid), 128'd0);
    out_ready = 1'b1;
    repeat (3) cyc();
    chk("flush_one_quiet", 128'(out_valid), 128'd0);
    send(32'h0220F1B3, 47, 32'h0);
    drain();
    out_ready = 1'b0;
    send(32'h002081B3, 0, 32'h0);
    send(32'h023100B3, 40, 32'h0);
    chk("pre_rst_full", 128'(in_ready), 128'd0);
    #3;
    rst = 1'b1;
    #1;
    chk("arst_valid", 128'(out_valid), 128'd0);
    chk("arst_ready", 128'(in_ready), 128'd1);
    chk("arst_fields", outs(), 128'd0);
    q.delete();
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'hFFF00293, 10, 32'hFFFFFFFF);
    chk("arst_latency", 128'(out_valid), 128'd1);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
